shift_pipe_ctrl: RTL and testbench

// - Handshaked two-stage pipeline controller placed directly upstream of barrelshifter.
// - Accepts shift commands on a valid/ready interface and registers them to drive the shifter inputs.
// - Captures the shifter's combinational result (y, zf, vf) into a registered valid/ready result port.
// - Sustains one command per cycle; stalls cleanly under downstream backpressure.

---
 rtl/shift_pipe_ctrl.sv | 103 ++++++++++
 tb/tb_shift_pipe_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_ctrl.sv
// shift_pipe_ctrl: two-stage valid/ready pipe wrapped around a barrelshifter.
// Optional SHIFT_PIPE_STICKY_EN adds a sticky overflow flag with clear input.
module shift_pipe_ctrl #(
  parameter int D_SIZE = 4,
  parameter int CNT_W = 8,
  localparam int S_W = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [D_SIZE-1:0] cmd_x_in,
  input  logic [S_W-1:0]    cmd_s_in,
  input  logic [2:0]        cmd_op_in,
  output logic [D_SIZE-1:0] bs_x_out,
  output logic [S_W-1:0]    bs_s_out,
  output logic [2:0]        bs_op_out,
  input  logic [D_SIZE-1:0] bs_y_in,
  input  logic              bs_zf_in,
  input  logic              bs_vf_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
  output logic [D_SIZE-1:0] res_y_out,
  output logic              res_zf_out,
  output logic              res_vf_out,
  output logic [CNT_W-1:0]  res_cnt_out
`ifdef SHIFT_PIPE_STICKY_EN
  ,
  input  logic              clr_sticky_in,
  output logic              vf_sticky_out
`endif
);

  logic s1_valid;
  logic s1_adv;
  logic s2_adv;
  logic cmd_fire;
  logic res_fire;

  // Ready depends only on pipe state, never on cmd_valid_in.
  always_comb begin
    s2_adv        = !res_valid_out || res_ready_in;
    s1_adv        = !s1_valid || s2_adv;
    cmd_ready_out = s1_adv;
    cmd_fire      = cmd_valid_in && s1_adv;
    res_fire      = res_valid_out && res_ready_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid  <= 1'b0;
      bs_x_out  <= '0;
      bs_s_out  <= '0;
      bs_op_out <= '0;
    end else begin
      if (s1_adv) s1_valid <= cmd_valid_in;
      if (cmd_fire) begin
        bs_x_out  <= cmd_x_in;
        bs_s_out  <= cmd_s_in;
        bs_op_out <= cmd_op_in;
      end
    end
  end

  // Result data holds its last value across bubbles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_valid_out <= 1'b0;
      res_y_out     <= '0;
      res_zf_out    <= 1'b0;
      res_vf_out    <= 1'b0;
    end else if (s2_adv) begin
      res_valid_out <= s1_valid;
      if (s1_valid) begin
        res_y_out  <= bs_y_in;
        res_zf_out <= bs_zf_in;
        res_vf_out <= bs_vf_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_cnt_out <= '0;
    end else if (res_fire) begin
      res_cnt_out <= res_cnt_out + CNT_W'(1);
    end
  end

`ifdef SHIFT_PIPE_STICKY_EN
  // Set has priority over clear when both occur in one cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vf_sticky_out <= 1'b0;
    end else if (res_fire && res_vf_out) begin
      vf_sticky_out <= 1'b1;
    end else if (clr_sticky_in) begin
      vf_sticky_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// tb_shift_pipe_ctrl: scoreboard bench for shift_pipe_ctrl with a
// behavioural barrelshifter attached; define SHIFT_PIPE_STICKY_EN for sticky.
module tb_shift_pipe_ctrl;

  typedef struct packed {
    logic [3:0] y;
    logic       zf;
    logic       vf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_x = '0;
  logic [1:0] cmd_s = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] bs_x;
  logic [1:0] bs_s;
  logic [2:0] bs_op;
  logic [3:0] bs_y;
  logic       bs_zf;
  logic       bs_vf;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_y;
  logic       res_zf;
  logic       res_vf;
  logic [7:0] res_cnt;
`ifdef SHIFT_PIPE_STICKY_EN
  logic       clr_sticky = 1'b0;
  logic       vf_sticky;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  shift_pipe_ctrl #(.D_SIZE(4), .CNT_W(8)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .cmd_valid_in  (cmd_valid),
    .cmd_ready_out (cmd_ready),
    .cmd_x_in      (cmd_x),
    .cmd_s_in      (cmd_s),
    .cmd_op_in     (cmd_op),
    .bs_x_out      (bs_x),
    .bs_s_out      (bs_s),
    .bs_op_out     (bs_op),
    .bs_y_in       (bs_y),
    .bs_zf_in      (bs_zf),
    .bs_vf_in      (bs_vf),
    .res_valid_out (res_valid),
    .res_ready_in  (res_ready),
    .res_y_out     (res_y),
    .res_zf_out    (res_zf),
    .res_vf_out    (res_vf),
    .res_cnt_out   (res_cnt)
`ifdef SHIFT_PIPE_STICKY_EN
    ,
    .clr_sticky_in (clr_sticky),
    .vf_sticky_out (vf_sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural barrelshifter: ASL keeps the sign bit, vf on lost magnitude bits.
  function automatic logic [5:0] shf(input logic [3:0] x, input logic [1:0] s,
                                     input logic [2:0] op);
    logic [7:0] d;
    logic [7:0] t;
    logic [3:0] y;
    logic       vf;
    d  = {x, x};
    vf = 1'b0;
    if (op[1]) begin
      t = op[2] ? (d << s) : (d >> s);
      y = op[2] ? t[7:4] : t[3:0];
    end else if (!op[2]) begin
      y = op[0] ? 4'($signed(x) >>> s) : (x >> s);
    end else if (!op[0]) begin
      y = x << s;
    end else begin
      y = {x[3], 3'(x[2:0] << s)};
      for (int i = 0; i < 3; i++)
        if (i >= 3 - int'(s) && x[i] != x[3]) vf = 1'b1;
    end
    return {y, (y == 4'd0), vf};
  endfunction

  always_comb {bs_y, bs_zf, bs_vf} = shf(bs_x, bs_s, bs_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("extra_result", 32'(res_y), 32'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_y", 32'(res_y), 32'(e.y));
        chk("res_zf", 32'(res_zf), 32'(e.zf));
        chk("res_vf", 32'(res_vf), 32'(e.vf));
      end
      chk("res_cnt_pre", 32'(res_cnt), 32'(pops % 256));
      pop_cyc.push_back(cyc);
      pops++;
    end
  end

  task automatic send(input logic [3:0] x, input logic [1:0] s, input logic [2:0] op,
                      input logic [3:0] ey, input logic ez, input logic ev);
    int t;
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_x = x;
    cmd_s = s;
    cmd_op = op;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back('{y: ey, zf: ez, vf: ev});
        break;
      end
      t++;
      if (t > 50) begin
        chk("cmd_accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || res_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n0;
    #12;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cnt", 32'(res_cnt), 32'd0);
    chk("rst_bs_x", 32'(bs_x), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    send(4'b1001, 2'd1, 3'b000, 4'b0100, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("lat_edge1_valid", 32'(res_valid), 32'd0);
    chk("lat_bs_x", 32'(bs_x), 32'b1001);
    @(negedge clk);
    chk("lat_edge2_valid", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("cnt_after_one", 32'(res_cnt), 32'd1);

    send(4'b0110, 2'd1, 3'b101, 4'b0100, 1'b0, 1'b1);
    idle();
    drain();
`ifdef SHIFT_PIPE_STICKY_EN
    @(negedge clk);
    chk("sticky_set", 32'(vf_sticky), 32'd1);
`endif
    send(4'b0001, 2'd1, 3'b000, 4'b0000, 1'b1, 1'b0);
    idle();
    drain();
    send(4'b1001, 2'd1, 3'b110, 4'b0011, 1'b0, 1'b0);
    idle();
    drain();

    n0 = pop_cyc.size();
    send(4'b1010, 2'd1, 3'b000, 4'b0101, 1'b0, 1'b0);
    send(4'b1100, 2'd2, 3'b010, 4'b0011, 1'b0, 1'b0);
    send(4'b0011, 2'd3, 3'b100, 4'b1000, 1'b0, 1'b0);
    send(4'b0000, 2'd0, 3'b001, 4'b0000, 1'b1, 1'b0);
    idle();
    drain();
    chk("b2b_count", 32'(pop_cyc.size() - n0), 32'd4);
    if (pop_cyc.size() - n0 == 4)
      for (int k = 1; k < 4; k++)
        chk("b2b_consec", 32'(pop_cyc[n0+k] - pop_cyc[n0+k-1]), 32'd1);

    res_ready = 1'b0;
    fork
      begin
        send(4'b0011, 2'd2, 3'b100, 4'b1100, 1'b0, 1'b0);
        send(4'b1000, 2'd3, 3'b001, 4'b1111, 1'b0, 1'b0);
        send(4'b0101, 2'd2, 3'b011, 4'b0101, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
          chk("stall_res_valid", 32'(res_valid), 32'd1);
          chk("stall_res_y", 32'(res_y), 32'b1100);
          chk("stall_bs_x", 32'(bs_x), 32'b1000);
          chk("stall_sb_depth", 32'(sb.size()), 32'd2);
        end
        @(posedge clk);
        #2;
        res_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_total", 32'(res_cnt), 32'(pops % 256));

`ifdef SHIFT_PIPE_STICKY_EN
    @(posedge clk);
    #2;
    clr_sticky = 1'b1;
    @(posedge clk);
    #2;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clr1", 32'(vf_sticky), 32'd0);
    res_ready = 1'b0;
    send(4'b0110, 2'd1, 3'b101, 4'b0100, 1'b0, 1'b1);
    idle();
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #2;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 32'(vf_sticky), 32'd1);
    @(posedge clk);
    #2;
    clr_sticky = 1'b1;
    @(posedge clk);
    #2;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_lone_clr", 32'(vf_sticky), 32'd0);
    drain();
`endif

    res_ready = 1'b0;
    send(4'b1111, 2'd1, 3'b000, 4'b0111, 1'b0, 1'b0);
    send(4'b0010, 2'd1, 3'b100, 4'b0100, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_res_valid", 32'(res_valid), 32'd1);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_cnt", 32'(res_cnt), 32'd0);
    sb.delete();
    pops = 0;
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
